// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared FSM state type and width/select helpers for mux_scan_reg.
// Optional feature macro used by the design: MUX_SCAN_MASK_EN.
package mux_scan_pkg;
    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int clamp_sel(input int sel, input int n);
        return (sel >= n) ? n - 1 : sel;
    endfunction
endpackage

// File: rtl/scan_ptr_gen.sv
// scan_ptr_gen: dwell counter and scan pointer with wrap detection for mux_scan_reg.
// Define MUX_SCAN_MASK_EN to add ch_mask and skip unmasked channels during the advance.
module scan_ptr_gen import mux_scan_pkg::*; #(
    parameter int N = 8,
    parameter int DWELL = 4,
    localparam int SW = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv_en,
    input  logic          clear,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]  ch_mask,
`endif
    output logic [SW-1:0] ptr,
    output logic          wrap_next
);
    localparam int DCW = sel_width(DWELL);
    logic [DCW-1:0] r_dwell;
    logic [SW-1:0]  r_ptr;
    logic [SW-1:0]  w_nxt;
    logic           r_pend;
    logic           w_wrapped;
    logic           w_last;
    assign w_last = r_dwell == DCW'(DWELL - 1);
`ifdef MUX_SCAN_MASK_EN
    // Descending search so the nearest enabled index after r_ptr wins; all-zero mask holds.
    always_comb begin
        w_nxt = r_ptr;
        w_wrapped = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (ch_mask[(int'(r_ptr) + i) % N]) begin
                w_nxt = SW'((int'(r_ptr) + i) % N);
                w_wrapped = (int'(r_ptr) + i) >= N;
            end
        end
    end
`else
    assign w_nxt = (r_ptr == SW'(N - 1)) ? '0 : r_ptr + 1'b1;
    assign w_wrapped = r_ptr == SW'(N - 1);
`endif
    // r_pend remembers a wrap so it can be flagged on the capture that returns to the start.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_dwell <= '0;
            r_ptr <= '0;
            r_pend <= 1'b0;
        end else if (adv_en) begin
            r_dwell <= w_last ? '0 : r_dwell + 1'b1;
            r_ptr <= w_last ? w_nxt : r_ptr;
            r_pend <= w_last && w_wrapped;
        end
    end
    assign ptr = r_ptr;
    assign wrap_next = r_pend;
endmodule

// File: rtl/mux_scan_reg.sv
// mux_scan_reg: N-channel W-bit registered mux with valid/ready output and auto-scan mode.
// Define MUX_SCAN_MASK_EN to add the ch_mask input that restricts which channels are scanned.
module mux_scan_reg import mux_scan_pkg::*; #(
    parameter int N = 8,
    parameter int W = 1,
    parameter int DWELL = 4,
    localparam int SW = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N*W-1:0] D,
    input  logic [SW-1:0] sel,
    input  logic          mode,
    input  logic          out_ready,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]  ch_mask,
`endif
    output logic [W-1:0]  Y,
    output logic          out_valid,
    output logic [SW-1:0] cur_sel,
    output logic          wrap
);
    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_y;
    logic          r_valid;
    logic [SW-1:0] r_cur;
    logic          r_wrap;
    logic          w_cap;
    logic          w_scan;
    logic          w_clear;
    logic          w_adv;
    logic          w_wrap_next;
    logic [SW-1:0] w_ptr;
    logic [SW-1:0] w_ch;
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end
    // Every non-reset state simply follows mode; the capture uses the state held this cycle.
    always_comb begin
        w_state_nxt = mode ? SCAN : MANUAL;
        w_scan = r_state == SCAN;
        w_cap = (r_state != IDLE) && (!r_valid || out_ready);
        w_clear = (r_state == MANUAL) && mode;
        w_adv = w_cap && w_scan;
        w_ch = w_scan ? w_ptr : SW'(clamp_sel(int'(sel), N));
    end
    scan_ptr_gen #(.N(N), .DWELL(DWELL)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .adv_en    (w_adv),
        .clear     (w_clear),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .ptr       (w_ptr),
        .wrap_next (w_wrap_next)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
            r_valid <= 1'b0;
            r_cur <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_adv && w_wrap_next;
            if (w_cap) begin
                r_y <= D[int'(w_ch) * W +: W];
                r_cur <= w_ch;
                r_valid <= 1'b1;
            end
        end
    end
    assign Y = r_y;
    assign out_valid = r_valid;
    assign cur_sel = r_cur;
    assign wrap = r_wrap;
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: table-driven check of manual, scan, backpressure, reset and clamp behaviour.
module tb_mux_scan_reg;
    typedef struct {
        logic       rst;
        logic       mode;
        logic       rdy;
        logic [2:0] sel;
        logic       chk;
        logic [3:0] y;
        logic [2:0] cur;
        logic       v;
        logic       w;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d = '0;
    logic [2:0]  sel = '0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  y;
    logic        out_valid;
    logic [2:0]  cur_sel;
    logic        wrap;
    logic [23:0] d6 = {4'hB, 4'h4, 4'h8, 4'h6, 4'hD, 4'h1};
    logic [2:0]  sel6 = '0;
    logic [3:0]  y6;
    logic        v6;
    logic [2:0]  cur6;
    logic        wrap6;
`ifdef MUX_SCAN_MASK_EN
    logic [7:0]  mask8 = '1;
    logic [5:0]  mask6 = '1;
`endif
    logic [3:0]  dval [8] = '{4'h3, 4'h7, 4'h9, 4'hA, 4'hC, 4'h5, 4'hE, 4'h2};
    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mux_scan_reg #(.N(8), .W(4), .DWELL(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .D         (d),
        .sel       (sel),
        .mode      (mode),
        .out_ready (out_ready),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask   (mask8),
`endif
        .Y         (y),
        .out_valid (out_valid),
        .cur_sel   (cur_sel),
        .wrap      (wrap)
    );

    mux_scan_reg #(.N(6), .W(4), .DWELL(1)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .D         (d6),
        .sel       (sel6),
        .mode      (1'b0),
        .out_ready (1'b1),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask   (mask6),
`endif
        .Y         (y6),
        .out_valid (v6),
        .cur_sel   (cur6),
        .wrap      (wrap6)
    );

    function automatic void add(input logic r, input logic m, input logic rd, input logic [2:0] s,
                                input logic c, input logic [3:0] ey, input logic [2:0] ec,
                                input logic ev, input logic ew);
        vec_t t;
        t.rst = r; t.mode = m; t.rdy = rd; t.sel = s; t.chk = c;
        t.y = ey; t.cur = ec; t.v = ev; t.w = ew;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) d[k*4 +: 4] = dval[k];
        add(1, 0, 1, 3, 1, 4'h0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 4'h0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 4'hA, 3, 1, 0);
        add(0, 0, 1, 5, 1, 4'h5, 5, 1, 0);
        add(0, 0, 0, 2, 1, 4'h5, 5, 1, 0);
        add(0, 0, 0, 2, 1, 4'h5, 5, 1, 0);
        add(0, 0, 1, 2, 1, 4'h9, 2, 1, 0);
        add(0, 1, 1, 2, 0, 4'h0, 0, 0, 0);
        for (int k = 0; k <= 20; k++)
            add(0, 1, 1, 2, 1, dval[(k/2)%8], 3'((k/2)%8), 1, k == 16);
        for (int k = 0; k < 3; k++)
            add(0, 1, 0, 2, 1, dval[2], 2, 1, 0);
        for (int k = 21; k <= 24; k++)
            add(0, 1, 1, 2, 1, dval[(k/2)%8], 3'((k/2)%8), 1, 0);
        add(1, 1, 1, 2, 1, 4'h0, 0, 0, 0);
        add(0, 1, 1, 2, 1, 4'h0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 1, 1, 2, 1, dval[k/2], 3'(k/2), 1, 0);
        add(0, 0, 1, 6, 0, 4'h0, 0, 0, 0);
        add(0, 0, 1, 6, 1, dval[6], 6, 1, 0);
        add(0, 0, 1, 7, 1, dval[7], 7, 1, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            mode = vecs[i].mode;
            out_ready = vecs[i].rdy;
            sel = vecs[i].sel;
            @(posedge clk);
            #1;
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d Y", i), 32'(y), 32'(vecs[i].y));
                chk($sformatf("vec%0d cur_sel", i), 32'(cur_sel), 32'(vecs[i].cur));
                chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].v));
                chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].w));
            end
        end

        sel6 = 3'd7;
        @(posedge clk); #1;
        chk("clamp sel7 cur_sel", 32'(cur6), 32'd5);
        chk("clamp sel7 Y", 32'(y6), 32'hB);
        chk("clamp out_valid", 32'(v6), 32'd1);
        sel6 = 3'd6;
        @(posedge clk); #1;
        chk("clamp sel6 cur_sel", 32'(cur6), 32'd5);
        chk("clamp sel6 Y", 32'(y6), 32'hB);
        sel6 = 3'd2;
        @(posedge clk); #1;
        chk("manual6 sel2 cur_sel", 32'(cur6), 32'd2);
        chk("manual6 sel2 Y", 32'(y6), 32'h6);
        chk("manual6 wrap", 32'(wrap6), 32'd0);
        sel6 = 3'd5;
        @(posedge clk); #1;
        chk("manual6 sel5 cur_sel", 32'(cur6), 32'd5);
        chk("manual6 sel5 Y", 32'(y6), 32'hB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
